// File: rtl/pcm_mic_capture_seq_if.sv
// Captured-sample stream between the PCM microphone sequencer and its consumer.
// The producer drives the word, its slot index and valid; the consumer drives ready.
interface pcm_mic_capture_seq_if #(
    parameter int unsigned DATA_BITS = 18
) ();
    logic [DATA_BITS-1:0] data_out;
    logic                 ch_out;
    logic                 valid;
    logic                 ready;

    modport master (output data_out, output ch_out, output valid, input ready);
    modport slave  (input data_out, input ch_out, input valid, output ready);
endinterface

// File: rtl/pcm_mic_capture_seq.sv
// I2S-style microphone capture sequencer: generates BCLK/WS, deserialises SD_IN MSB first
// and presents each captured slot word on a valid/ready stream with frame-end flagging.
module pcm_mic_capture_seq #(
    parameter int unsigned DATA_BITS = 18,
    parameter int unsigned SLOT_BITS = 32,
    parameter int unsigned CHANNELS  = 1,
    parameter int unsigned CLK_DIV   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  continuous,
    input  logic                  sd_in,
    output logic                  bclk,
    output logic                  ws,
    output logic                  en_bclk,
    output logic                  reset_int,
    output logic                  overrun,
    output logic                  done,
    pcm_mic_capture_seq_if.master cap
);
    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CntW = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] BitLast = CntW'(SLOT_BITS - 1);
    localparam logic [CntW-1:0] CapBit  = CntW'(DATA_BITS - 1);

    typedef enum logic [1:0] {StIdle, StClear, StRun} state_e;

    state_e               state_q, state_d;
    logic [DivW-1:0]      div_q, div_d;
    logic [CntW-1:0]      bit_q, bit_d;
    logic                 slot_q, slot_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, shift_nx;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 ch_q, ch_d;
    logic                 valid_q, valid_d;
    logic                 bclk_q, bclk_d;
    logic                 ws_q, ws_d;
    logic                 en_q, en_d;
    logic                 rint_q, rint_d;
    logic                 ovr_q, ovr_d;
    logic                 done_q, done_d;
    logic                 wrap, rise, fall;

    // Only the newest DATA_BITS bits survive, so the register needs no per-slot clear.
    assign shift_nx = (shift_q << 1) | DATA_BITS'(sd_in);
    assign wrap     = (div_q == DivLast);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        slot_d  = slot_q;
        shift_d = shift_q;
        data_d  = data_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        bclk_d  = bclk_q;
        ws_d    = ws_q;
        en_d    = en_q;
        rint_d  = 1'b0;
        ovr_d   = 1'b0;
        done_d  = 1'b0;
        rise    = 1'b0;
        fall    = 1'b0;

        if (valid_q && cap.ready) valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                en_d   = 1'b0;
                bclk_d = 1'b0;
                ws_d   = 1'b0;
                if (enable) begin
                    state_d = StClear;
                    rint_d  = 1'b1;
                end
            end
            StClear: begin
                div_d   = '0;
                bit_d   = '0;
                slot_d  = 1'b0;
                shift_d = '0;
                en_d    = 1'b1;
                state_d = StRun;
            end
            StRun: begin
                rise  = wrap && !bclk_q;
                fall  = wrap && bclk_q;
                div_d = wrap ? '0 : div_q + DivW'(1);
                if (wrap) bclk_d = !bclk_q;
                // WS follows the slot counter on the falling edge ahead of bit 0.
                if (fall) ws_d = slot_q;
                if (rise) begin
                    shift_d = shift_nx;
                    bit_d   = (bit_q == BitLast) ? '0 : bit_q + CntW'(1);
                    if (bit_q == BitLast) slot_d = !slot_q;
                    if (bit_q == CapBit && (!slot_q || CHANNELS == 2)) begin
                        data_d  = shift_nx;
                        ch_d    = slot_q;
                        valid_d = 1'b1;
                        ovr_d   = valid_q && !cap.ready;
                    end
                    if (bit_q == BitLast && slot_q) begin
                        done_d = 1'b1;
                        if (!continuous) state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            div_q   <= '0;
            bit_q   <= '0;
            slot_q  <= 1'b0;
            shift_q <= '0;
            data_q  <= '0;
            ch_q    <= 1'b0;
            valid_q <= 1'b0;
            bclk_q  <= 1'b0;
            ws_q    <= 1'b0;
            en_q    <= 1'b0;
            rint_q  <= 1'b0;
            ovr_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            slot_q  <= slot_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            bclk_q  <= bclk_d;
            ws_q    <= ws_d;
            en_q    <= en_d;
            rint_q  <= rint_d;
            ovr_q   <= ovr_d;
            done_q  <= done_d;
        end
    end

    assign bclk         = bclk_q;
    assign ws           = ws_q;
    assign en_bclk      = en_q;
    assign reset_int    = rint_q;
    assign overrun      = ovr_q;
    assign done         = done_q;
    assign cap.data_out = data_q;
    assign cap.ch_out   = ch_q;
    assign cap.valid    = valid_q;
endmodule

// File: tb/tb_pcm_mic_capture_seq.sv
// Bench for pcm_mic_capture_seq: stereo, mono and 16/16 div-1 instances run side by side,
// each against a frame-position reference model fed by random or fixed serial data.
module tb_pcm_mic_capture_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic continuous = 1'b0;
    logic ready = 1'b1;
    bit   use_pattern = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;

    logic [2:0]  en_v, rint_v, valid_v, ch_v, any_v;
    logic [31:0] data_a [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned DB = (g == 2) ? 16 : 18;
        localparam int unsigned SB = (g == 2) ? 16 : 32;
        localparam int unsigned CH = (g == 1) ? 1 : 2;
        localparam int unsigned CD = (g == 2) ? 1 : 2;
        localparam int unsigned FB = 2 * SB;

        logic sd = 1'b0;
        logic bclk, ws, en, rint, ovr, done;

        pcm_mic_capture_seq_if #(.DATA_BITS(DB)) ifc ();
        assign ifc.ready = ready;

        pcm_mic_capture_seq #(
            .DATA_BITS(DB),
            .SLOT_BITS(SB),
            .CHANNELS (CH),
            .CLK_DIV  (CD)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .enable    (enable),
            .continuous(continuous),
            .sd_in     (sd),
            .bclk      (bclk),
            .ws        (ws),
            .en_bclk   (en),
            .reset_int (rint),
            .overrun   (ovr),
            .done      (done),
            .cap       (ifc.master)
        );

        assign en_v[g]    = en;
        assign rint_v[g]  = rint;
        assign valid_v[g] = ifc.valid;
        assign ch_v[g]    = ifc.ch_out;
        assign data_a[g]  = 32'(ifc.data_out);
        assign any_v[g]   = bclk | ws | en | rint | ovr | done | ifc.valid | ifc.ch_out
                            | (|ifc.data_out);

        // Reference model: each BCLK rise is frame position pos; slot and bit follow arithmetically.
        logic        sd_e = 1'b0, rdy_e = 1'b1, cont_e = 1'b0;
        bit          prev_b, prev_en, m_valid, exp_idle, e_ovr, e_done, rose, cap_now;
        int          pos, slot, bitn, run, last_done, rises, dones, ovrs;
        logic [31:0] word, pat;

        always @(posedge clk) begin
            sd_e   <= sd;
            rdy_e  <= ready;
            cont_e <= continuous;
        end

        always @(negedge clk) begin
            if (!rst_n) begin
                prev_b = 0; prev_en = 0; m_valid = 0; exp_idle = 0;
                pos = 0; run = 0; last_done = -1; word = 0; sd = 1'b0;
            end else begin
                if (exp_idle) begin
                    check("stop_idle", 32'({en, bclk, ws}), 32'd0);
                    exp_idle = 0;
                end
                if (en && !prev_en) begin
                    pos = 0;
                    run = 0;
                end
                rose    = en && bclk && !prev_b;
                e_ovr   = 0;
                e_done  = 0;
                slot    = pos / SB;
                bitn    = pos % SB;
                cap_now = rose && (bitn == DB - 1) && (slot == 0 || CH == 2);
                if (rose) begin
                    check("ws", 32'(ws), 32'(slot));
                    if (bitn == 0) word = 0;
                    if (bitn < DB) word = (word << 1) | 32'(sd_e);
                    if (pos == FB - 1) begin
                        e_done = 1;
                        if (!cont_e) exp_idle = 1;
                    end
                    pos = (pos + 1) % FB;
                    rises++;
                end
                if (cap_now) begin
                    e_ovr   = m_valid && !rdy_e;
                    m_valid = 1;
                    check("data", data_a[g], word);
                    check("ch", 32'(ifc.ch_out), 32'(slot));
                end else if (m_valid && rdy_e) begin
                    m_valid = 0;
                end
                check("flags", 32'({ifc.valid, ovr, done}), 32'({m_valid, e_ovr, e_done}));
                if (en) begin
                    if (prev_en && bclk != prev_b) begin
                        check("half_period", 32'(run), 32'(CD));
                        run = 1;
                    end else begin
                        run++;
                    end
                end
                if (!en) last_done = -1;
                if (done) begin
                    dones++;
                    if (last_done >= 0) check("frame_spacing", 32'(cyc - last_done), 4 * SB * CD);
                    last_done = cyc;
                end
                if (ovr) ovrs++;
                prev_b  = bclk;
                prev_en = en;
                if (!bclk) begin
                    if (use_pattern && (pos % SB) < DB) begin
                        pat = (pos / SB == 0) ? 32'h2A5A5 : 32'h15A5A;
                        sd  = pat[DB - 1 - (pos % SB)];
                    end else begin
                        sd = 1'($urandom_range(0, 1));
                    end
                end
            end
        end
    end

    task automatic start();
        @(negedge clk) enable = 1'b1;
        @(negedge clk) enable = 1'b0;
        check("clear_pulse", 32'(rint_v), 32'h7);
        check("clear_no_bclk", 32'(en_v), 32'h0);
        @(negedge clk);
        check("run_en_bclk", 32'(en_v), 32'h7);
        check("clear_one_cycle", 32'(rint_v), 32'h0);
    endtask

    task automatic wait_idle(input int limit, input bit rnd);
        int k = 0;
        while (en_v != 3'b000 && k < limit) begin
            @(negedge clk);
            if (rnd) ready = 1'($urandom_range(0, 1));
            k++;
        end
        check("idle_wait", 32'(en_v), 32'h0);
    endtask

    initial begin
        int r1, o0, d0, r0, k;
        logic [2:0] acc;

        repeat (3) @(negedge clk);
        check("reset_state", 32'(any_v), 32'h0);
        #1 rst_n = 1'b1;
        acc = '0;
        repeat (20) begin
            @(negedge clk);
            acc |= any_v;
        end
        check("idle_quiet", 32'(acc), 32'h0);

        // Fixed words, consumer always ready.
        use_pattern = 1'b1;
        r1 = g_dut[1].rises;
        start();
        wait_idle(800, 1'b0);
        check("stereo_data", data_a[0], 32'h15A5A);
        check("stereo_ch", 32'(ch_v[0]), 32'd1);
        check("mono_data", data_a[1], 32'h2A5A5);
        check("mono_ch", 32'(ch_v[1]), 32'd0);
        check("mono_rises", 32'(g_dut[1].rises - r1), 32'd64);
        check("edge_data", data_a[2], 32'h5A5A);

        // Backpressure across both captures of a stereo frame.
        @(negedge clk) ready = 1'b0;
        o0 = g_dut[0].ovrs;
        start();
        wait_idle(800, 1'b0);
        check("bp_overrun", 32'(g_dut[0].ovrs - o0), 32'd1);
        check("bp_data", data_a[0], 32'h15A5A);
        check("bp_valid", 32'(valid_v[0]), 32'd1);
        @(negedge clk) ready = 1'b1;
        @(negedge clk);
        check("bp_accept", 32'(valid_v[0]), 32'd0);

        // Continuous frames with random data and random ready.
        use_pattern = 1'b0;
        continuous  = 1'b1;
        d0 = g_dut[0].dones;
        start();
        k = 0;
        while (g_dut[0].dones - d0 < 2 && k < 1000) begin
            @(negedge clk);
            ready = 1'($urandom_range(0, 1));
            k++;
        end
        check("cont_reach_frame3", 32'(g_dut[0].dones - d0), 32'd2);
        continuous = 1'b0;
        wait_idle(800, 1'b1);
        check("cont_frames", 32'(g_dut[0].dones - d0), 32'd3);

        repeat (3) begin
            start();
            wait_idle(800, 1'b1);
        end

        // Reset at bit 10 of slot 0, then a clean frame.
        @(negedge clk) ready = 1'b1;
        use_pattern = 1'b1;
        start();
        r0 = g_dut[0].rises;
        k = 0;
        while (g_dut[0].rises - r0 < 11 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("reach_bit10", 32'(g_dut[0].rises - r0), 32'd11);
        #1 rst_n = 1'b0;
        #1 check("async_reset", 32'(any_v), 32'h0);
        repeat (2) @(negedge clk);
        check("held_reset", 32'(any_v), 32'h0);
        #1 rst_n = 1'b1;
        start();
        wait_idle(800, 1'b0);
        check("post_reset_data", data_a[0], 32'h15A5A);
        check("post_reset_mono", data_a[1], 32'h2A5A5);
        check("post_reset_edge", data_a[2], 32'h5A5A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
